// File: rtl/uart_pkg.sv
// Constants shared by the UART-side blocks: byte width, grant index width
// and the state encodings of the transmit arbiter FSM.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int GRANT_W     = 3;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set bit of mask, searching upward from
// ptr+1 with wrap-around. Purely combinational so it can be shared by other
// dispatchers that keep their own pointer.
module rr_pick
   import uart_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]   mask,
   input  logic [GRANT_W-1:0] ptr,
   output logic               found,
   output logic [GRANT_W-1:0] index
);

   logic [2*N_REQ-1:0] dbl_shift;
   logic [N_REQ-1:0]   rot;

   // Doubling the mask turns the wrap-around search into a plain shift;
   // rot[k] is the requester at offset k+1 from the pointer.
   assign dbl_shift = {mask, mask} >> (int'(ptr) + 1);
   assign rot       = dbl_shift[N_REQ-1:0];

   // Scan from the far end so the lowest offset is the one left standing.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            index = GRANT_W'((int'(ptr) + 1 + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters. Round-robin grant,
// packets are kept atomic by locking onto the owner until its last byte,
// and an abandoned lock is released after LOCK_TO idle cycles.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = UART_DATA_W,
   parameter int LOCK_TO = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        last,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic [DATA_W-1:0]       tx_data,
   output logic                    tx_start,
   input  logic                    tx_ready,
   output logic [GRANT_W-1:0]      grant_id,
   output logic                    locked
);

   localparam int CNT_W = $clog2(LOCK_TO);

   logic [1:0]         state_reg;
   logic [GRANT_W-1:0] ptr_reg;
   logic [GRANT_W-1:0] grant_reg;
   logic [DATA_W-1:0]  tx_data_reg;
   logic [N_REQ-1:0]   ack_reg;
   logic               tx_start_reg;
   logic               last_reg;
   logic               locked_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic [DATA_W-1:0]  data_arr [N_REQ];
   logic [N_REQ-1:0]   owner_mask;
   logic [N_REQ-1:0]   win_mask;
   logic [N_REQ-1:0]   eligible;
   logic [DATA_W-1:0]  win_data;
   logic               win_last;
   logic               owner_req;
   logic               pick_found;
   logic [GRANT_W-1:0] pick_idx;
   logic               grant_now;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign data_arr[gi]   = req_data[gi*DATA_W +: DATA_W];
         assign owner_mask[gi] = (grant_reg == GRANT_W'(gi));
         assign win_mask[gi]   = pick_found && (pick_idx == GRANT_W'(gi));
      end
   endgenerate

   // While a packet is open only its owner may compete.
   assign eligible  = locked_reg ? (req & owner_mask) : req;
   assign owner_req = |(req & owner_mask);
   assign win_last  = |(last & win_mask);
   assign grant_now = (state_reg == ST_IDLE) && tx_ready && pick_found;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .mask  (eligible),
      .ptr   (ptr_reg),
      .found (pick_found),
      .index (pick_idx)
   );

   // Byte mux for the winning requester.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_mask[i]) win_data = data_arr[i];
      end
   end

   // Grant FSM: capture byte on the grant edge, pulse start/ack in ISSUE,
   // then follow tx_ready down and back up before arbitrating again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= GRANT_W'(N_REQ - 1);
         grant_reg    <= '0;
         tx_data_reg  <= '0;
         ack_reg      <= '0;
         tx_start_reg <= 1'b0;
         last_reg     <= 1'b0;
      end else begin
         ack_reg      <= '0;
         tx_start_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (grant_now) begin
                  tx_data_reg  <= win_data;
                  grant_reg    <= pick_idx;
                  ptr_reg      <= pick_idx;
                  last_reg     <= win_last;
                  ack_reg      <= win_mask;
                  tx_start_reg <= 1'b1;
                  state_reg    <= ST_ISSUE;
               end
            end
            ST_ISSUE:     state_reg <= ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!tx_ready) state_reg <= ST_WAIT_DONE;
            ST_WAIT_DONE: if (tx_ready) state_reg <= ST_IDLE;
            default:      state_reg <= ST_IDLE;
         endcase
      end
   end

   // Packet lock and abandoned-lock timeout. The pointer is left on the
   // timed-out owner so every other requester is searched ahead of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         if (state_reg == ST_ISSUE) begin
            locked_reg <= !last_reg;
         end
         if (state_reg == ST_IDLE && locked_reg && !owner_req) begin
            if (cnt_reg == CNT_W'(LOCK_TO - 1)) begin
               locked_reg <= 1'b0;
               cnt_reg    <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   assign ack      = ack_reg;
   assign tx_data  = tx_data_reg;
   assign tx_start = tx_start_reg;
   assign grant_id = grant_reg;
   assign locked   = locked_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART_TX model whose
// frame keeps tx_ready low for FRAME-1 cycles after each start.
module tb_uart_tx_arbiter;

   localparam int N_REQ   = 4;
   localparam int DATA_W  = 8;
   localparam int LOCK_TO = 8;
   localparam int FRAME   = 10;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [N_REQ-1:0]        req = '0;
   logic [N_REQ-1:0]        last = '0;
   logic [N_REQ*DATA_W-1:0] req_data = '0;
   logic [N_REQ-1:0]        ack;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_start;
   logic                    tx_ready;
   logic [2:0]              grant_id;
   logic                    locked;

   logic       hold_low = 1'b0;
   logic [7:0] busy_cnt;
   int         chk_cnt  = 0;
   int         pass_cnt = 0;

   uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LOCK_TO(LOCK_TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .last     (last),
      .req_data (req_data),
      .ack      (ack),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_ready (tx_ready),
      .grant_id (grant_id),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy for FRAME-1 cycles after seeing tx_start.
   always @(posedge clk or posedge rst) begin
      if (rst)                busy_cnt <= '0;
      else if (tx_start)      busy_cnt <= 8'(FRAME - 1);
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1'b1;
   end
   assign tx_ready = !hold_low && (busy_cnt == 0);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic r, input logic l, input logic [7:0] d);
      req[i]              = r;
      last[i]             = l;
      req_data[i*8 +: 8]  = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      last = '0;
      hold_low = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Advance until tx_start is seen (bounded); cyc returns the cycles taken.
   task automatic wait_start(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!tx_start && cyc < 100);
      check_eq("start_seen", 32'(tx_start), 32'd1);
      $display("start: cyc=%0d grant=%0d data=%02h ack=%b locked=%0b",
               cyc, grant_id, tx_data, ack, locked);
   endtask

   initial begin
      int cyc;
      logic [N_REQ-1:0] ack_seen;
      logic [7:0] pkt [3];
      pkt[0] = 8'h47; pkt[1] = 8'h55; pkt[2] = 8'h0A;

      // Reset state
      @(negedge clk);
      check_eq("rst_ack",      32'(ack), 0);
      check_eq("rst_tx_data",  32'(tx_data), 0);
      check_eq("rst_tx_start", 32'(tx_start), 0);
      check_eq("rst_grant",    32'(grant_id), 0);
      check_eq("rst_locked",   32'(locked), 0);
      rst = 1'b0;

      // Single byte: start and ack exactly one cycle after the offer
      set_req(0, 1'b1, 1'b1, 8'h41);
      check_eq("single_no_start_yet", 32'(tx_start), 0);
      wait_start(cyc);
      check_eq("single_latency", cyc, 1);
      check_eq("single_ack",     32'(ack), 32'b0001);
      check_eq("single_data",    32'(tx_data), 32'h41);
      set_req(0, 1'b0, 1'b0, 8'h00);
      tick();
      check_eq("single_pulse_start", 32'(tx_start), 0);
      check_eq("single_pulse_ack",   32'(ack), 0);
      check_eq("single_locked",      32'(locked), 0);

      // Contention: 0,1,2,3 in order, 12-cycle spacing
      do_reset();
      for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b1, 8'(8'h10 + i));
      for (int k = 0; k < N_REQ; k++) begin
         wait_start(cyc);
         check_eq($sformatf("cont_spacing%0d", k), cyc, (k == 0) ? 1 : 12);
         check_eq($sformatf("cont_grant%0d", k), 32'(grant_id), k);
         check_eq($sformatf("cont_ack%0d", k),   32'(ack), 32'(1 << k));
         check_eq($sformatf("cont_data%0d", k),  32'(tx_data), 32'(8'h10 + k));
         req[k] = 1'b0;
      end

      // Packet lock: req[1] sends 3 bytes while req[2] waits
      do_reset();
      set_req(2, 1'b1, 1'b1, 8'h22);
      set_req(1, 1'b1, 1'b0, pkt[0]);
      for (int b = 0; b < 3; b++) begin
         wait_start(cyc);
         check_eq($sformatf("pkt_grant%0d", b), 32'(grant_id), 1);
         check_eq($sformatf("pkt_data%0d", b),  32'(tx_data), 32'(pkt[b]));
         if (b < 2) set_req(1, 1'b1, (b == 1), pkt[b+1]);
         else       set_req(1, 1'b0, 1'b0, 8'h00);
         tick();
         check_eq($sformatf("pkt_locked%0d", b), 32'(locked), (b < 2) ? 1 : 0);
      end
      wait_start(cyc);
      check_eq("pkt_next_grant", 32'(grant_id), 2);
      check_eq("pkt_next_data",  32'(tx_data), 32'h22);
      req[2] = 1'b0;

      // Lock timeout: req[3] abandons its packet, req[0] waits it out
      do_reset();
      set_req(3, 1'b1, 1'b0, 8'h33);
      wait_start(cyc);
      check_eq("to_grant3", 32'(grant_id), 3);
      set_req(3, 1'b0, 1'b0, 8'h00);
      set_req(0, 1'b1, 1'b1, 8'h50);
      ack_seen = '0;
      for (int c = 0; c < 18; c++) begin
         tick();
         ack_seen |= ack;
      end
      check_eq("to_locked_before", 32'(locked), 1);
      check_eq("to_no_ack",        32'(ack_seen), 0);
      tick();
      check_eq("to_locked_fall", 32'(locked), 0);
      check_eq("to_ack_still0",  32'(ack), 0);
      tick();
      check_eq("to_start0", 32'(tx_start), 1);
      check_eq("to_ack0",   32'(ack), 32'b0001);
      check_eq("to_data0",  32'(tx_data), 32'h50);
      req[0] = 1'b0;

      // Transmitter busy: no start until tx_ready rises
      do_reset();
      hold_low = 1'b1;
      set_req(2, 1'b1, 1'b1, 8'h77);
      ack_seen = '0;
      cyc = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         ack_seen |= ack;
         cyc += int'(tx_start);
      end
      check_eq("busy_no_start", cyc, 0);
      check_eq("busy_no_ack",   32'(ack_seen), 0);
      hold_low = 1'b0;
      tick();
      check_eq("busy_start", 32'(tx_start), 1);
      check_eq("busy_ack",   32'(ack), 32'b0100);
      check_eq("busy_data",  32'(tx_data), 32'h77);
      req[2] = 1'b0;

      // Reset mid-frame while locked
      do_reset();
      set_req(3, 1'b1, 1'b0, 8'h3C);
      wait_start(cyc);
      set_req(3, 1'b1, 1'b1, 8'h3D);
      set_req(0, 1'b1, 1'b1, 8'h0F);
      for (int c = 0; c < 4; c++) tick();
      check_eq("mid_locked", 32'(locked), 1);
      #2 rst = 1'b1;
      #1;
      check_eq("mid_async_locked", 32'(locked), 0);
      check_eq("mid_async_data",   32'(tx_data), 0);
      check_eq("mid_async_grant",  32'(grant_id), 0);
      @(negedge clk);
      rst = 1'b0;
      wait_start(cyc);
      check_eq("mid_grant0", 32'(grant_id), 0);
      check_eq("mid_ack0",   32'(ack), 32'b0001);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
